// File: rtl/mem_responder_pkg.sv
// Shared types and sizing helpers for the multicycle memory responder.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_t;

  // Word-index width for a given depth; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between a memory requester (master) and the responder (slave).
interface mem_responder_if;
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mem_responder_wait_counter.sv
// Loadable down-counter that paces the WAIT state; the zero flag ends the wait.
module mem_wait_counter #(
  parameter  int WAIT_STATES = 2,
  localparam int CNT_W       = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = CNT_W'(WAIT_STATES);
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_responder.sv
// Multicycle word memory target with programmable wait states.
// Define MEM_MISALIGN_TRAP_EN to reject addresses with addr[1:0] != 0.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus_io
);

  localparam int IDX_W = idx_width(DEPTH_WORDS);

  mem_state_t        state_q, state_d;
  logic              req_ready, rsp_valid, accept, exec, cnt_zero;
  logic              we_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              err_q;
  logic              acc_err;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  mem_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .clock  (clock),
    .reset  (reset),
    .load_i (accept),
    .en_i   (state_q == MEM_WAIT),
    .zero_o (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= MEM_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (bus_io.req_valid) state_d = MEM_WAIT;
      MEM_WAIT: if (cnt_zero)         state_d = MEM_RESP;
      MEM_RESP: if (bus_io.rsp_ready) state_d = MEM_IDLE;
      default:                        state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == MEM_IDLE);
    rsp_valid = (state_q == MEM_RESP);
    accept    = req_ready & bus_io.req_valid;
    exec      = (state_q == MEM_WAIT) & cnt_zero;
  end

  // Request fields are pure data: captured at acceptance, never reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      we_q    <= bus_io.req_we;
      addr_q  <= bus_io.req_addr;
      wdata_q <= bus_io.req_wdata;
    end
  end

  assign idx = addr_q[IDX_W+1:2];

`ifdef MEM_MISALIGN_TRAP_EN
  assign acc_err = (|addr_q[WORD_W-1:IDX_W+2]) | (|addr_q[1:0]);
`else
  logic unused_lsb;
  assign unused_lsb = ^addr_q[1:0];
  assign acc_err    = |addr_q[WORD_W-1:IDX_W+2];
`endif

  always_ff @(posedge clock) begin
    if (exec && we_q && !acc_err)
      mem_q[idx] <= wdata_q;
  end

  // Response registers only change on the execute edge, so they hold through RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (exec) begin
      err_q   <= acc_err;
      rdata_q <= (acc_err || we_q) ? '0 : mem_q[idx];
    end
  end

  assign bus_io.req_ready = req_ready;
  assign bus_io.rsp_valid = rsp_valid;
  assign bus_io.rsp_rdata = rdata_q;
  assign bus_io.rsp_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder (WAIT_STATES = 2 and 0 instances).
module tb_mem_responder;

  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if bus0 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut0 (
    .clock (clk), .reset (rst), .bus_io (bus0)
  );
  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut1 (
    .clock (clk), .reset (rst), .bus_io (bus1)
  );

  bit          sel = 1'b0;
  logic        drv_valid = 1'b0, drv_we = 1'b0, drv_rready = 1'b0;
  logic [31:0] drv_addr = '0, drv_wdata = '0;

  assign bus0.req_valid = drv_valid & ~sel;
  assign bus1.req_valid = drv_valid &  sel;
  assign bus0.rsp_ready = drv_rready & ~sel;
  assign bus1.rsp_ready = drv_rready &  sel;
  assign bus0.req_we = drv_we;    assign bus1.req_we = drv_we;
  assign bus0.req_addr = drv_addr;  assign bus1.req_addr = drv_addr;
  assign bus0.req_wdata = drv_wdata; assign bus1.req_wdata = drv_wdata;

  wire        o_req_ready = sel ? bus1.req_ready : bus0.req_ready;
  wire        o_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
  wire [31:0] o_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
  wire        o_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mem_m [2][DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit model_err(input logic [31:0] addr);
    bit e;
    e = (addr >= 32'(4 * DEPTH));
`ifdef MEM_MISALIGN_TRAP_EN
    e = e | (addr[1:0] != 2'b00);
`endif
    return e;
  endfunction

  // One complete transaction on the selected instance, with optional response backpressure.
  task automatic txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    int          lat, ws, d;
    bit          err;
    logic [31:0] exp_rd;
    d  = sel ? 1 : 0;
    ws = sel ? 0 : 2;
    chk("req_ready_idle", 32'(o_req_ready), 32'd1);
    drv_valid = 1'b1; drv_we = we; drv_addr = addr; drv_wdata = wdata;
    @(posedge clk); #1;
    drv_valid = 1'b0; drv_we = 1'($urandom); drv_addr = $urandom; drv_wdata = $urandom;

    err = model_err(addr);
    if (!err && we) mem_m[d][addr[7:2]] = wdata;
    exp_rd = (err || we) ? 32'd0 : mem_m[d][addr[7:2]];

    lat = 0;
    while (!o_rsp_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(ws + 1));
    chk("rsp_err", 32'(o_rsp_err), 32'(err));
    chk("rsp_rdata", o_rsp_rdata, exp_rd);
    chk("req_ready_busy", 32'(o_req_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(o_rsp_valid), 32'd1);
      chk("hold_rdata", o_rsp_rdata, exp_rd);
      chk("hold_err", 32'(o_rsp_err), 32'(err));
      chk("hold_req_ready", 32'(o_req_ready), 32'd0);
    end
    drv_rready = 1'b1;
    @(posedge clk); #1;
    drv_rready = 1'b0;
    chk("consumed_valid", 32'(o_rsp_valid), 32'd0);
    chk("consumed_ready", 32'(o_req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 0);

    txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    txn(1'b0, 32'h10, 32'h0, 5);
    txn(1'b1, 32'h100, 32'h12345678, 0);
    txn(1'b0, 32'h0, 32'h0, 0);
    txn(1'b1, 32'h13, 32'hA5A50013, 0);
    txn(1'b0, 32'h10, 32'h0, 1);

    // Reset while a write is still waiting: it must be dropped.
    drv_valid = 1'b1; drv_we = 1'b1; drv_addr = 32'h8; drv_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(o_req_ready), 32'd1);
    chk("midrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("midrst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("midrst_rsp_err", 32'(o_rsp_err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    txn(1'b0, 32'h8, 32'h0, 0);

    for (int i = 0; i < 150; i++) begin
      case ($urandom % 8)
        0:       a = $urandom | 32'h100;
        1:       a = $urandom % 256;
        default: a = ($urandom % DEPTH) * 4;
      endcase
      txn(1'($urandom), a, $urandom, int'($urandom % 4));
    end

    sel = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 32'h4, 32'h0BADF00D, 0);
    txn(1'b0, 32'h4, 32'h0, 2);
    txn(1'b1, 32'h200, 32'h11111111, 0);
    txn(1'b0, 32'h4, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
